vga_dac_lookup: RTL

Colour-lookup stage directly downstream of the planar/text pixel generators. It takes the 4-bit pixel attribute and its aligned `video_on_h`/`horiz_sync` flags, maps the attribute through a 16-entry attribute palette and then a 256-entry, 18-bit DAC colour table, and emits blanked 6-bit R/G/B with matching sync. It also owns the host-side palette and DAC programming port, including the VGA-style R, G, B triplet sequencing with index auto-increment.

---
 rtl/vga_dac_lookup_if.sv | 42 ++++
 rtl/vga_dac_lookup.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_dac_lookup_if.sv
// -----------------------------------------------------------------------------
// vga_dac_lookup_if
//
// Host programming bus of the colour-lookup stage: attribute palette writes
// and the VGA-style DAC index/data port.
//
//   pal_we, pal_adr, pal_dat_i   attribute palette write (entry, 6-bit data)
//   dac_wr_idx_we                load the DAC write index from dac_idx_i
//   dac_rd_idx_we                load the DAC read index from dac_idx_i
//   dac_idx_i                    index value for either load
//   dac_dat_we, dac_dat_i        write one colour component (R, G, B order)
//   dac_dat_rd                   read one colour component (R, G, B order)
//   dac_dat_o                    component read back
//
// The master modport is the host side; the slave modport is the lookup stage.
// -----------------------------------------------------------------------------
interface vga_dac_lookup_if;
    logic       pal_we;
    logic [3:0] pal_adr;
    logic [5:0] pal_dat_i;
    logic       dac_wr_idx_we;
    logic       dac_rd_idx_we;
    logic [7:0] dac_idx_i;
    logic       dac_dat_we;
    logic       dac_dat_rd;
    logic [5:0] dac_dat_i;
    logic [5:0] dac_dat_o;

    modport master (
        output pal_we, pal_adr, pal_dat_i,
        output dac_wr_idx_we, dac_rd_idx_we, dac_idx_i,
        output dac_dat_we, dac_dat_rd, dac_dat_i,
        input  dac_dat_o
    );

    modport slave (
        input  pal_we, pal_adr, pal_dat_i,
        input  dac_wr_idx_we, dac_rd_idx_we, dac_idx_i,
        input  dac_dat_we, dac_dat_rd, dac_dat_i,
        output dac_dat_o
    );
endinterface

// File: rtl/vga_dac_lookup.sv
// -----------------------------------------------------------------------------
// vga_dac_lookup
//
// Colour-lookup stage behind the planar/text pixel generators. A 4-bit pixel
// attribute is mapped through a 16 x 6-bit attribute palette, then through a
// 256 x 18-bit DAC colour table ({R,G,B}, 6 bits each), and emitted as blanked
// 6-bit RGB with the display-active and hsync flags delayed to match.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   enable             advances the video pipeline (host port ignores it)
//   attr               pixel attribute
//   video_on_h_i       display-active flag aligned with attr
//   horiz_sync_i       hsync aligned with attr
//   color_select       DAC index bits [7:6]
//   host               host programming bus (vga_dac_lookup_if.slave)
//   red_o/green_o/blue_o  pixel colour, 0 while blanked
//   video_on_h_o, horiz_sync_o  flags delayed by the pipeline latency
//
// Build option:
//   VGA_DAC_READBACK_EN  when defined, the DAC read index, read sequencer and
//                        dac_dat_o readback path are built. Otherwise dac_dat_o
//                        is tied to 0 and the read strobes are ignored.
//
// Video latency is three enabled cycles from attr to the RGB outputs:
//   S1 palette lookup, S2 DAC table lookup, S3 blanking.
// -----------------------------------------------------------------------------
module vga_dac_lookup (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [3:0] attr,
    input  logic       video_on_h_i,
    input  logic       horiz_sync_i,
    input  logic [1:0] color_select,
    vga_dac_lookup_if.slave host,
    output logic [5:0] red_o,
    output logic [5:0] green_o,
    output logic [5:0] blue_o,
    output logic       video_on_h_o,
    output logic       horiz_sync_o
);

    // Host triplet position shared by the write and read sequencers.
    typedef enum logic [1:0] {
        PH_R = 2'd0,
        PH_G = 2'd1,
        PH_B = 2'd2
    } phase_e;

    // -------------------------------------------------------------------------
    // Attribute palette
    // -------------------------------------------------------------------------
    logic [5:0] palette_q [16];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                palette_q[i] <= '0;
            end
        end else if (host.pal_we) begin
            palette_q[host.pal_adr] <= host.pal_dat_i;
        end
    end

    // -------------------------------------------------------------------------
    // DAC colour table: one host write port, one video read port and (when
    // readback is built) one host read port. All reads see the pre-edge
    // contents, so a same-cycle write to the entry being read returns the old
    // value.
    // -------------------------------------------------------------------------
    logic [17:0] dac_mem [256];
    logic        dac_we;
    logic [17:0] dac_wdata;
    logic [7:0]  wr_idx_q, wr_idx_d;

    // NOTE: the colour table is a RAM and is deliberately left out of reset so
    // it maps onto memory macros; software must program it before display.
    always_ff @(posedge clk) begin
        if (dac_we) begin
            dac_mem[wr_idx_q] <= dac_wdata;
        end
    end

    // -------------------------------------------------------------------------
    // Write sequencer: R and G are staged, the B write commits the whole entry
    // and steps the index. An index load restarts the triplet and takes
    // priority over a data strobe in the same cycle.
    // -------------------------------------------------------------------------
    phase_e     wr_phase_q, wr_phase_d;
    logic [5:0] tmp_r_q, tmp_r_d;
    logic [5:0] tmp_g_q, tmp_g_d;

    always_comb begin
        // NOTE: every output of a combinational block gets a default up front;
        // a path that leaves one unassigned would infer a latch.
        wr_phase_d = wr_phase_q;
        wr_idx_d   = wr_idx_q;
        tmp_r_d    = tmp_r_q;
        tmp_g_d    = tmp_g_q;
        dac_we     = 1'b0;
        dac_wdata  = {tmp_r_q, tmp_g_q, host.dac_dat_i};

        if (host.dac_wr_idx_we) begin
            wr_idx_d   = host.dac_idx_i;
            wr_phase_d = PH_R;
        end else if (host.dac_dat_we) begin
            unique case (wr_phase_q)
                PH_R: begin
                    tmp_r_d    = host.dac_dat_i;
                    wr_phase_d = PH_G;
                end
                PH_G: begin
                    tmp_g_d    = host.dac_dat_i;
                    wr_phase_d = PH_B;
                end
                PH_B: begin
                    dac_we     = 1'b1;
                    wr_idx_d   = wr_idx_q + 8'd1;   // 255 wraps to 0
                    wr_phase_d = PH_R;
                end
                default: wr_phase_d = PH_R;
            endcase
        end
    end

    // NOTE: clocked state is updated with non-blocking assignments only, so
    // every flop samples the pre-edge value of every other flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_phase_q <= PH_R;
            wr_idx_q   <= '0;
            tmp_r_q    <= '0;
            tmp_g_q    <= '0;
        end else begin
            wr_phase_q <= wr_phase_d;
            wr_idx_q   <= wr_idx_d;
            tmp_r_q    <= tmp_r_d;
            tmp_g_q    <= tmp_g_d;
        end
    end

    // -------------------------------------------------------------------------
    // Read sequencer: each strobe returns the next component of the entry at
    // the read index; after B the index steps. The returned component holds
    // until the next strobe.
    // -------------------------------------------------------------------------
`ifdef VGA_DAC_READBACK_EN
    phase_e      rd_phase_q, rd_phase_d;
    logic [7:0]  rd_idx_q, rd_idx_d;
    logic [5:0]  dac_dat_q, dac_dat_d;
    logic [17:0] rd_word;

    assign rd_word = dac_mem[rd_idx_q];

    always_comb begin
        rd_phase_d = rd_phase_q;
        rd_idx_d   = rd_idx_q;
        dac_dat_d  = dac_dat_q;

        if (host.dac_rd_idx_we) begin
            rd_idx_d   = host.dac_idx_i;
            rd_phase_d = PH_R;
        end else if (host.dac_dat_rd) begin
            unique case (rd_phase_q)
                PH_R: begin
                    dac_dat_d  = rd_word[17:12];
                    rd_phase_d = PH_G;
                end
                PH_G: begin
                    dac_dat_d  = rd_word[11:6];
                    rd_phase_d = PH_B;
                end
                PH_B: begin
                    dac_dat_d  = rd_word[5:0];
                    rd_idx_d   = rd_idx_q + 8'd1;
                    rd_phase_d = PH_R;
                end
                default: rd_phase_d = PH_R;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_phase_q <= PH_R;
            rd_idx_q   <= '0;
            dac_dat_q  <= '0;
        end else begin
            rd_phase_q <= rd_phase_d;
            rd_idx_q   <= rd_idx_d;
            dac_dat_q  <= dac_dat_d;
        end
    end

    assign host.dac_dat_o = dac_dat_q;
`else
    // Readback not built: the read controls have no effect.
    logic unused_rd_ports;
    assign unused_rd_ports = host.dac_rd_idx_we ^ host.dac_dat_rd;
    assign host.dac_dat_o  = '0;
`endif

    // -------------------------------------------------------------------------
    // Video pipeline. Every register here holds while enable is low.
    //   S1: pal_q      <= palette[attr]
    //   S2: rgb_q      <= dac[{color_select, pal_q}]
    //   S3: rgb_out_q  <= video_on ? rgb_q : 0
    // The flag shift registers are three deep; bit 1 is the flag that travels
    // with rgb_q, so it is the one that blanks S3.
    // -------------------------------------------------------------------------
    logic [5:0]  pal_q, pal_d;
    logic [17:0] rgb_q, rgb_d;
    logic [17:0] rgb_out_q, rgb_out_d;
    logic [2:0]  von_sr_q, von_sr_d;
    logic [2:0]  hs_sr_q, hs_sr_d;

    always_comb begin
        pal_d     = pal_q;
        rgb_d     = rgb_q;
        rgb_out_d = rgb_out_q;
        von_sr_d  = von_sr_q;
        hs_sr_d   = hs_sr_q;

        if (enable) begin
            pal_d     = palette_q[attr];
            rgb_d     = dac_mem[{color_select, pal_q}];
            rgb_out_d = von_sr_q[1] ? rgb_q : 18'd0;
            von_sr_d  = {von_sr_q[1:0], video_on_h_i};
            hs_sr_d   = {hs_sr_q[1:0], horiz_sync_i};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pal_q     <= '0;
            rgb_q     <= '0;
            rgb_out_q <= '0;
            von_sr_q  <= '0;
            hs_sr_q   <= '0;
        end else begin
            pal_q     <= pal_d;
            rgb_q     <= rgb_d;
            rgb_out_q <= rgb_out_d;
            von_sr_q  <= von_sr_d;
            hs_sr_q   <= hs_sr_d;
        end
    end

    assign red_o        = rgb_out_q[17:12];
    assign green_o      = rgb_out_q[11:6];
    assign blue_o       = rgb_out_q[5:0];
    assign video_on_h_o = von_sr_q[2];
    assign horiz_sync_o = hs_sr_q[2];

endmodule
